pe_operand_unit: RTL and testbench
==================================

# pe_operand_unit

Operand-supply and memory-bridge stage for the RISC-V processing element. It holds the architectural register file and answers the PE's operand requests on the A/B mux inputs with a `data_Ready` handshake. It sequences the PE's load/store requests onto a single-port data-memory interface and returns load data with `mem_ack`. It also commits the PE's writebacks, forwarding them into any operand read issued in the same cycle.

## Interface
- `XLEN`, 32: datapath width.
- `NREGS`, 32: register count; `rs*/rd` index width is log2(NREGS).
- `MEM_TIMEOUT`, 16: maximum cycles spent in MEM_WAIT before the unit aborts with an error.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reg_select`  in  1  PE operand-fetch request (level).
- `rs1Out`, `rs2Out`  in  5  source register indices.
- `rdOut`  in  5  destination index.
- `rdWrite`  in  1  writeback strobe.
- `result_out`  in  XLEN  writeback data.
- `mem_read`, `mem_write`  in  1  PE memory request (level).
- `mem_address`  in  XLEN  byte address.
- `messReg`  in  XLEN  store data.
- `AmuxIn`, `BmuxIn`  out  XLEN  operand A/B; on load completion, AmuxIn carries the load data.
- `data_Ready`  out  1  operands valid.
- `mem_ack`  out  1  memory access complete.
- `mem_err`  out  1  the last access timed out.
- `busy`  out  1  the FSM is not in IDLE.
- `dmem_req`  out  1  one-cycle request strobe to data memory.
- `dmem_we`  out  1  write enable, qualified by `dmem_req`.
- `dmem_addr`, `dmem_wdata`  out  XLEN  request address and write data.
- `dmem_rdata`  in  XLEN  read data.
- `dmem_valid`  in  1  memory response strobe.

## Operation
- Register file: NREGS x XLEN flops, all cleared by reset.
  - x0 always reads 0; writes to x0 are dropped.
  - A write occurs at the clock edge where `rdWrite` is 1 and `rdOut` is not 0.
- Forwarding: if an operand read and a write in the same cycle target the same nonzero index, the operand takes `result_out`.
- FSM states: IDLE, OPREADY, MEM_REQ, MEM_WAIT, MEM_DONE.
- IDLE:
  - `reg_select` = 1: latch rf[rs1]/rf[rs2] (with forwarding) into `AmuxIn`/`BmuxIn`, set `data_Ready`, go to OPREADY.
  - Otherwise, `mem_read` or `mem_write` = 1: go to MEM_REQ.
  - `reg_select` has priority over memory requests.
- OPREADY:
  - `data_Ready` is held and the operands are frozen.
  - `mem_read` or `mem_write` = 1: go to MEM_REQ; `data_Ready` stays high.
  - Else `reg_select` = 0: clear `data_Ready`, go to IDLE.
- MEM_REQ, exactly one cycle:
  - `dmem_req` = 1; `dmem_addr` = `mem_address`; `dmem_wdata` = `messReg`.
  - `dmem_we` = `mem_write` AND NOT `mem_read`. If both are asserted, the access is a read.
  - Go to MEM_WAIT and clear the timeout counter.
- MEM_WAIT:
  - `dmem_valid` = 1: for a read, latch `AmuxIn` = `dmem_rdata` (a write leaves `AmuxIn` unchanged); set `mem_ack`, clear `mem_err`, go to MEM_DONE.
  - The counter reaches `MEM_TIMEOUT` - 1 with no response: set `mem_ack` and `mem_err`; a read drives `AmuxIn` = 0. Go to MEM_DONE.
- MEM_DONE:
  - `mem_ack` is held until `mem_read` and `mem_write` are both 0.
  - Then clear `mem_ack` and `data_Ready`, and go to IDLE. `mem_err` keeps its value until the next access completes.
- `dmem_valid` outside MEM_WAIT is ignored, including a late response after a timeout.
- Writeback runs independently of FSM state.

## Timing
- Reset values: all outputs 0, including `AmuxIn`, `BmuxIn`, `dmem_addr`, `dmem_wdata`, `mem_err` and `busy`. The FSM enters IDLE.
- Reset asserted mid-transaction aborts it immediately; no `mem_ack` is produced for that transaction.
- Operand latency: `reg_select` sampled at edge N gives `data_Ready` = 1 and valid operands after edge N.
- Memory latency:
  - Request sampled at edge N: `dmem_req` is high during cycle N+1.
  - `dmem_valid` sampled at edge M ≥ N+2: `mem_ack` is high after edge M.
  - Minimum request-to-ack latency is 3 edges.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then write x11 = 0x25 (`rdWrite`, `rdOut` = 11). Raise `reg_select` with rs1 = 11, rs2 = 0 → after 1 edge: `data_Ready` = 1, `AmuxIn` = 0x25, `BmuxIn` = 0.
- Forwarding: `rdWrite` with rd = 12, `result_out` = 0x4 in the same cycle as `reg_select` with rs2 = 12 → `BmuxIn` = 0x4. A write to x0 followed by a read of x0 → 0.
- Load: in OPREADY, `mem_read` with `mem_address` = 0x48; memory returns 0x80A5 two cycles after `dmem_req` → `dmem_we` = 0, `dmem_addr` = 0x48, `AmuxIn` = 0x80A5, `mem_ack` = 1 until `mem_read` drops.
- Store: `mem_write` with `messReg` = 0xA2C080A5 → `dmem_req` = 1 and `dmem_we` = 1 for exactly 1 cycle with `dmem_wdata` = 0xA2C080A5; `mem_ack` follows `dmem_valid`.
- Timeout: `mem_read` with no `dmem_valid` → `mem_ack` = 1, `mem_err` = 1, `AmuxIn` = 0 after 16 cycles in MEM_WAIT. A later `dmem_valid` has no effect.
- Drive `reset` low in MEM_WAIT → outputs clear asynchronously; after release the FSM is in IDLE and a subsequent `dmem_valid` is ignored.

Source files
------------

// File: rtl/pe_operand_unit.sv
// Operand-supply and data-memory bridge for the RISC-V processing element.
// It holds the register file, serves operand fetches with forwarding, and runs single-port load/store handshakes.
module pe_operand_unit #(
   parameter  int XLEN        = 32,
   parameter  int NREGS       = 32,
   parameter  int MEM_TIMEOUT = 16,
   localparam int AW          = $clog2(NREGS),
   localparam int CW          = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reg_select,
   input  logic [AW-1:0]   rs1Out,
   input  logic [AW-1:0]   rs2Out,
   input  logic [AW-1:0]   rdOut,
   input  logic            rdWrite,
   input  logic [XLEN-1:0] result_out,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [XLEN-1:0] mem_address,
   input  logic [XLEN-1:0] messReg,
   output logic [XLEN-1:0] AmuxIn,
   output logic [XLEN-1:0] BmuxIn,
   output logic            data_Ready,
   output logic            mem_ack,
   output logic            mem_err,
   output logic            busy,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_OPREADY, S_MEM_REQ, S_MEM_WAIT, S_MEM_DONE
   } state_t;

   state_t            r_state, w_next;
   logic [XLEN-1:0]   r_rf [NREGS];
   logic [XLEN-1:0]   r_a, r_b, r_addr, r_wdata;
   logic              r_ready, r_ack, r_err, r_busy, r_req, r_we, r_is_read;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   w_op_a, w_op_b;
   logic              w_mem_rq, w_timeout, w_wr_en;

   assign w_mem_rq  = mem_read | mem_write;
   assign w_timeout = (r_cnt == CW'(MEM_TIMEOUT - 1));
   assign w_wr_en   = rdWrite && (rdOut != '0);

   // Operand read with same-cycle writeback bypass; x0 is hardwired to zero.
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      if (rs1Out != '0) w_op_a = (w_wr_en && rdOut == rs1Out) ? result_out : r_rf[rs1Out];
      if (rs2Out != '0) w_op_b = (w_wr_en && rdOut == rs2Out) ? result_out : r_rf[rs2Out];
   end

   // NOTE: the register file is real flops cleared by reset, so it cannot map onto a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      end else if (w_wr_en) begin
         r_rf[rdOut] <= result_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (reg_select) w_next = S_OPREADY;
                     else if (w_mem_rq) w_next = S_MEM_REQ;
         S_OPREADY:  if (w_mem_rq) w_next = S_MEM_REQ;
                     else if (!reg_select) w_next = S_IDLE;
         S_MEM_REQ:  w_next = S_MEM_WAIT;
         S_MEM_WAIT: if (dmem_valid || w_timeout) w_next = S_MEM_DONE;
         S_MEM_DONE: if (!w_mem_rq) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // NOTE: every output is a flop updated with non-blocking assignments, so no input reaches an output combinationally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a <= '0;  r_b <= '0;  r_addr <= '0;  r_wdata <= '0;
         r_ready <= 1'b0;  r_ack <= 1'b0;  r_err <= 1'b0;  r_busy <= 1'b0;
         r_req <= 1'b0;  r_we <= 1'b0;  r_is_read <= 1'b0;  r_cnt <= '0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_req  <= 1'b0;
         if ((r_state == S_IDLE || r_state == S_OPREADY) && w_next == S_MEM_REQ) begin
            r_req     <= 1'b1;
            r_we      <= mem_write & ~mem_read;
            r_is_read <= mem_read;
            r_addr    <= mem_address;
            r_wdata   <= messReg;
         end
         case (r_state)
            S_IDLE: if (reg_select) begin
               r_a     <= w_op_a;
               r_b     <= w_op_b;
               r_ready <= 1'b1;
            end
            S_OPREADY: if (!w_mem_rq && !reg_select) r_ready <= 1'b0;
            S_MEM_REQ: begin
               r_we  <= 1'b0;
               r_cnt <= '0;
            end
            S_MEM_WAIT: begin
               if (dmem_valid) begin
                  if (r_is_read) r_a <= dmem_rdata;
                  r_ack <= 1'b1;
                  r_err <= 1'b0;
               end else if (w_timeout) begin
                  if (r_is_read) r_a <= '0;
                  r_ack <= 1'b1;
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_MEM_DONE: if (!w_mem_rq) begin
               r_ack   <= 1'b0;
               r_ready <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign AmuxIn     = r_a;
   assign BmuxIn     = r_b;
   assign data_Ready = r_ready;
   assign mem_ack    = r_ack;
   assign mem_err    = r_err;
   assign busy       = r_busy;
   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_pe_operand_unit.sv
// Directed bench for pe_operand_unit: operand fetch, forwarding, load, store, timeout and mid-access reset.
module tb_pe_operand_unit;

   logic        clk, reset, reg_select, rdWrite, mem_read, mem_write, dmem_valid;
   logic [4:0]  rs1Out, rs2Out, rdOut;
   logic [31:0] result_out, mem_address, messReg, dmem_rdata;
   logic [31:0] AmuxIn, BmuxIn, dmem_addr, dmem_wdata;
   logic        data_Ready, mem_ack, mem_err, busy, dmem_req, dmem_we;
   int          n_checks = 0;
   int          n_errors = 0;

   pe_operand_unit dut (
      .clk(clk), .reset(reset), .reg_select(reg_select),
      .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut), .rdWrite(rdWrite),
      .result_out(result_out), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .messReg(messReg),
      .AmuxIn(AmuxIn), .BmuxIn(BmuxIn), .data_Ready(data_Ready),
      .mem_ack(mem_ack), .mem_err(mem_err), .busy(busy),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;  reg_select = 1'b0;  rdWrite = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;
      dmem_valid = 1'b0;  rs1Out = '0;  rs2Out = '0;  rdOut = '0;
      result_out = '0;  mem_address = '0;  messReg = '0;  dmem_rdata = '0;
      #1 reset = 1'b0;
      #1;
      check("rst_ready", data_Ready, 0);  check("rst_a", AmuxIn, 0);     check("rst_b", BmuxIn, 0);
      check("rst_ack", mem_ack, 0);       check("rst_err", mem_err, 0);  check("rst_busy", busy, 0);
      check("rst_req", dmem_req, 0);      check("rst_we", dmem_we, 0);
      check("rst_addr", dmem_addr, 0);    check("rst_wdata", dmem_wdata, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Write x11 then read it back with x0
      rdWrite = 1'b1;  rdOut = 5'd11;  result_out = 32'h25;
      tick();
      rdWrite = 1'b0;  reg_select = 1'b1;  rs1Out = 5'd11;  rs2Out = 5'd0;
      tick();
      check("op_ready", data_Ready, 1);  check("op_a_x11", AmuxIn, 32'h25);
      check("op_b_x0", BmuxIn, 0);       check("op_busy", busy, 1);
      reg_select = 1'b0;
      tick();
      check("op_release", data_Ready, 0);  check("op_idle", busy, 0);

      // Same-cycle write to x12 forwards into the operand
      rdWrite = 1'b1;  rdOut = 5'd12;  result_out = 32'h4;
      reg_select = 1'b1;  rs1Out = 5'd11;  rs2Out = 5'd12;
      tick();
      check("fwd_b", BmuxIn, 32'h4);  check("fwd_a", AmuxIn, 32'h25);
      rdWrite = 1'b0;  reg_select = 1'b0;
      tick();

      // x0 writes are dropped, including the forwarding path
      rdWrite = 1'b1;  rdOut = 5'd0;  result_out = 32'hDEAD;
      tick();
      reg_select = 1'b1;  rs1Out = 5'd0;  rs2Out = 5'd12;
      tick();
      check("x0_read", AmuxIn, 0);  check("x12_stored", BmuxIn, 32'h4);
      rdWrite = 1'b0;

      // Load from OPREADY
      mem_read = 1'b1;  mem_address = 32'h48;  messReg = 32'h1234;
      tick();
      check("ld_req", dmem_req, 1);  check("ld_we", dmem_we, 0);
      check("ld_addr", dmem_addr, 32'h48);  check("ld_ready_held", data_Ready, 1);
      tick();
      check("ld_req_pulse", dmem_req, 0);
      tick();
      check("ld_no_ack_yet", mem_ack, 0);
      dmem_valid = 1'b1;  dmem_rdata = 32'h80A5;
      tick();
      check("ld_ack", mem_ack, 1);  check("ld_data", AmuxIn, 32'h80A5);  check("ld_err", mem_err, 0);
      dmem_valid = 1'b0;
      tick();
      check("ld_ack_held", mem_ack, 1);
      mem_read = 1'b0;  reg_select = 1'b0;
      tick();
      check("ld_ack_clr", mem_ack, 0);  check("ld_ready_clr", data_Ready, 0);  check("ld_idle", busy, 0);

      // Store from IDLE
      mem_write = 1'b1;  mem_address = 32'h100;  messReg = 32'hA2C080A5;
      tick();
      check("st_req", dmem_req, 1);  check("st_we", dmem_we, 1);  check("st_wdata", dmem_wdata, 32'hA2C080A5);
      tick();
      check("st_req_pulse", dmem_req, 0);  check("st_we_pulse", dmem_we, 0);
      dmem_valid = 1'b1;  dmem_rdata = 32'hFFFF;
      tick();
      check("st_ack", mem_ack, 1);  check("st_a_kept", AmuxIn, 32'h80A5);
      dmem_valid = 1'b0;  mem_write = 1'b0;
      tick();
      check("st_ack_clr", mem_ack, 0);

      // Read and write together is a read
      mem_read = 1'b1;  mem_write = 1'b1;  mem_address = 32'h80;
      tick();
      check("rw_req", dmem_req, 1);  check("rw_we", dmem_we, 0);
      tick();
      dmem_valid = 1'b1;  dmem_rdata = 32'h5555;
      tick();
      check("rw_data", AmuxIn, 32'h5555);
      dmem_valid = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;
      tick();

      // Timeout: 16 edges in MEM_WAIT with no response
      mem_read = 1'b1;  mem_address = 32'h200;
      tick();
      tick();
      repeat (15) tick();
      check("to_not_yet", mem_ack, 0);
      tick();
      check("to_ack", mem_ack, 1);  check("to_err", mem_err, 1);  check("to_a_zero", AmuxIn, 0);
      dmem_valid = 1'b1;  dmem_rdata = 32'h7777;
      tick();
      check("to_late_a", AmuxIn, 0);  check("to_late_err", mem_err, 1);
      dmem_valid = 1'b0;  mem_read = 1'b0;
      tick();
      check("to_ack_clr", mem_ack, 0);  check("to_err_kept", mem_err, 1);  check("to_idle", busy, 0);

      // Reset in MEM_WAIT aborts the access
      mem_read = 1'b1;  mem_address = 32'h300;
      tick();
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      check("ar_busy", busy, 0);  check("ar_addr", dmem_addr, 0);  check("ar_err", mem_err, 0);
      check("ar_a", AmuxIn, 0);   check("ar_ready", data_Ready, 0);
      mem_read = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      dmem_valid = 1'b1;  dmem_rdata = 32'h9999;
      tick();
      check("ar_valid_ignored", mem_ack, 0);  check("ar_a_kept", AmuxIn, 0);  check("ar_still_idle", busy, 0);
      dmem_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
